regfile_write_arbiter: RTL and testbench
========================================

# regfile_write_arbiter

Shares the register file's single write port (WriteReg/WriteData/RegWrite) among up to four writeback requesters, such as ALU result and memory load. Each requester has a one-entry holding buffer and a valid/ready handshake. One buffered write per cycle is arbitrated into a write stage and launched toward the register file on the falling clock edge, so RegWrite is stable across the high phase of the clock-gated write. The block also exports a per-register pending mask for hazard detection upstream.

## Interface
- NUM_REQ, 2, number of requesters (legal 1..4)
- clk  in  1  system clock; all state on rising edge except the launch flops (falling edge)
- reset  in  1  asynchronous, active-high; clears all state immediately
- req_valid  in  NUM_REQ  requester i offers a write
- req_ready  out  NUM_REQ  requester i may transfer this cycle
- req_reg  in  5*NUM_REQ  destination register, slice [5i+4:5i]
- req_data  in  32*NUM_REQ  write data, slice [32i+31:32i]
- WriteReg  out  5  to register file write address
- WriteData  out  32  to register file write data
- RegWrite  out  1  to register file write enable
- grant  out  NUM_REQ  one-hot, requester whose buffered entry moves to the write stage this cycle
- pending  out  32  bit r set while any write to register r is buffered, staged or launched

## Operation
- Transfer: req_valid[i] & req_ready[i] at a rising edge loads buf_i (valid, reg, data).
- req_ready[i] = ~buf_valid[i] | grant[i]. This allows a back-to-back stream of one write per cycle per requester when granted every cycle.
- Arbitration is combinational over buf_valid. The selected entry loads the write stage (wr_valid/wr_reg/wr_data) at the rising edge, and its buffer empties that same edge unless refilled.
- The write stage always accepts; it never stalls.
- The launch flops copy the write stage on the falling edge and drive WriteReg, WriteData and RegWrite directly.
- The register file commits on the next rising edge of clk&RegWrite.
- Back-to-back writes keep RegWrite high. The gated clock then toggles with clk, giving one commit per cycle.
- Register 0 is an ordinary register; no filtering.
- pending is the OR of the decoded valid buffers, the write stage and the launch flops. A bit stays set until the commit edge.
- Multiple writes to the same register commit in grant order; the last granted value remains.
- Width rules: data is passed through unmodified; no arithmetic.

## Timing
- Reset values: req_ready all 1, grant 0, RegWrite 0, WriteReg 0, WriteData 0, pending 0, round-robin pointer = NUM_REQ-1 (requester 0 first).
- Latency: transfer at edge E0, staged at E1, launched at the falling edge between E1 and E2, committed at E2. This is 2 cycles from accept to commit, and pending is set for exactly those cycles.
- Throughput is 1 write per cycle total.
- Simultaneous valid on all requesters: each is granted once per NUM_REQ cycles under round-robin.
- Simultaneous grant and new transfer on the same requester: the buffer is refilled, and buf_valid stays 1.
- Reset mid-operation: buffered, staged and launched writes are dropped. RegWrite falls asynchronously and no partial commit occurs. pending clears immediately.
- NUM_REQ=1: grant = buf_valid, and the pointer is unused.

## Configuration
- REGARB_ROUND_ROBIN_EN defined: the pointer holds the last granted index, and the search begins at pointer+1 modulo NUM_REQ. The pointer updates only on a grant.
- Not defined: fixed priority, where the lowest index wins. Pointer logic is removed, and requester 0 can starve the others.

## Structure
- Package regarb_pkg contains:
  - REG_ADDR_W=5, DATA_W=32, NUM_REGS=32, MAX_REQ=4
  - a packed write-entry typedef (valid, reg, data)
- Sub-module regarb_rr_pick: a NUM_REQ-wide one-hot priority picker with rotating base input. In fixed-priority mode the base is tied to 0.

## Test plan
- Reset release, then req 0 writes reg 5 = 0xDEADBEEF at E0 → RegWrite high after the falling edge following E1, commit at E2. pending[5] is set E0..E2, then cleared.
- Both requesters valid every cycle, with the macro defined → grant alternates 01,10,01,…. Each req_ready stays high on its grant cycles and reaches 50% throughput.
- Macro undefined, same stimulus → req 0 is granted every cycle and req 1 is stalled with req_ready[1]=0 until req 0 drops valid.
- Req 0 and req 1 both target reg 7 (0x1, 0x2) in the same cycle with round-robin from reset → reg 7 ends at 0x2, and pending[7] is held until the second commit.
- Assert reset while two writes are in flight → RegWrite drops within the cycle with no clock edge needed, and the register file contents are unchanged.
- Writes to reg 0 (0xFFFFFFFF) → committed, and a readback of reg 0 returns 0xFFFFFFFF.

Source files
------------

// File: rtl/regarb_pkg.sv
// Shared widths and the write-entry record for the register-file write arbiter.
// Latency: none, declarations only.
// Backpressure: not applicable.
package regarb_pkg;

   localparam int REG_ADDR_W = 5;
   localparam int DATA_W     = 32;
   localparam int NUM_REGS   = 32;
   localparam int MAX_REQ    = 4;
   localparam int IDX_W      = $clog2(MAX_REQ);

   // One buffered, staged or launched register write
   typedef struct packed {
      logic                  valid;
      logic [REG_ADDR_W-1:0] regno;
      logic [DATA_W-1:0]     data;
   } wr_entry_t;

endpackage

// File: rtl/regarb_rr_pick.sv
// One-hot picker: grants the first set request at or after index base, wrapping modulo N.
// Latency: combinational.
// Backpressure: none; gnt is all zero when no request is set.
module regarb_rr_pick
   import regarb_pkg::*;
#(
   parameter int N = 2
) (
   input  logic [N-1:0]     req,
   input  logic [IDX_W-1:0] base,
   output logic [N-1:0]     gnt
);

   logic found;

   // scan from base upward with wrap-around and keep the first hit
   always_comb begin
      gnt   = '0;
      found = 1'b0;
      for (int k = 0; k < N; k++) begin
         if (!found && req[(int'(base) + k) % N]) begin
            gnt[(int'(base) + k) % N] = 1'b1;
            found = 1'b1;
         end
      end
   end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the register-file write port among NUM_REQ one-entry writeback buffers; REGARB_ROUND_ROBIN_EN selects round-robin, otherwise fixed priority (lowest index wins).
// Latency: accept at E0, staged at E1, launched on the falling edge after E1, committed by the register file at E2.
// Backpressure: req_ready[i] is low only while buffer i is full and not granted this cycle; the write stage never stalls.
module regfile_write_arbiter
   import regarb_pkg::*;
#(
   parameter int NUM_REQ = 2
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [NUM_REQ-1:0]            req_valid,
   output logic [NUM_REQ-1:0]            req_ready,
   input  logic [REG_ADDR_W*NUM_REQ-1:0] req_reg,
   input  logic [DATA_W*NUM_REQ-1:0]     req_data,
   output logic [REG_ADDR_W-1:0]         WriteReg,
   output logic [DATA_W-1:0]             WriteData,
   output logic                          RegWrite,
   output logic [NUM_REQ-1:0]            grant,
   output logic [NUM_REGS-1:0]           pending
);

   wr_entry_t          buf_q [NUM_REQ];
   wr_entry_t          wr_q;
   wr_entry_t          launch_q;
   wr_entry_t          sel;
   logic [NUM_REQ-1:0] buf_valid;
   logic [IDX_W-1:0]   base;

   // occupancy vector feeding the arbiter
   always_comb begin
      buf_valid = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         buf_valid[i] = buf_q[i].valid;
      end
   end

   regarb_rr_pick #(
      .N (NUM_REQ)
   ) u_pick (
      .req  (buf_valid),
      .base (base),
      .gnt  (grant)
   );

`ifdef REGARB_ROUND_ROBIN_EN
   logic [IDX_W-1:0] ptr_q;
   logic [IDX_W-1:0] gnt_idx;

   // encode the one-hot grant into an index
   always_comb begin
      gnt_idx = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant[i]) gnt_idx = IDX_W'(i);
      end
   end

   // pointer holds the last granted requester; reset value makes requester 0 first
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ptr_q <= IDX_W'(NUM_REQ - 1);
      end else if (|grant) begin
         ptr_q <= gnt_idx;
      end
   end

   // search starts one past the last winner; a single requester has nothing to rotate
   always_comb begin
      base = '0;
      if (NUM_REQ > 1) begin
         base = (ptr_q == IDX_W'(NUM_REQ - 1)) ? '0 : ptr_q + IDX_W'(1);
      end
   end
`else
   assign base = '0;
`endif

   // a full buffer can still take a new write in the cycle it drains
   assign req_ready = ~buf_valid | grant;

   // one-entry holding buffers: load on transfer, empty when granted and not refilled
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NUM_REQ; i++) begin
            buf_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NUM_REQ; i++) begin
            if (req_valid[i] && req_ready[i]) begin
               buf_q[i].valid <= 1'b1;
               buf_q[i].regno <= req_reg[REG_ADDR_W*i +: REG_ADDR_W];
               buf_q[i].data  <= req_data[DATA_W*i +: DATA_W];
            end else if (grant[i]) begin
               buf_q[i].valid <= 1'b0;
            end
         end
      end
   end

   // route the granted buffer toward the write stage
   always_comb begin
      sel = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant[i]) sel = buf_q[i];
      end
   end

   // write stage always accepts; address/data hold when idle
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_q <= '0;
      end else begin
         wr_q.valid <= sel.valid;
         if (sel.valid) begin
            wr_q.regno <= sel.regno;
            wr_q.data  <= sel.data;
         end
      end
   end

   // launch on the falling edge so RegWrite is settled across the gated clock high phase
   always_ff @(negedge clk or posedge reset) begin
      if (reset) begin
         launch_q <= '0;
      end else begin
         launch_q <= wr_q;
      end
   end

   assign RegWrite  = launch_q.valid;
   assign WriteReg  = launch_q.regno;
   assign WriteData = launch_q.data;

   // hazard mask: buffered plus staged writes. A launched write is still held by the
   // write stage until its commit edge, so the stage term covers it; reading the launch
   // flops directly would keep the bit set for half a cycle past the commit.
   always_comb begin
      pending = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (buf_q[i].valid) pending[buf_q[i].regno] = 1'b1;
      end
      if (wr_q.valid) pending[wr_q.regno] = 1'b1;
   end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Self-checking bench for regfile_write_arbiter with a gated-clock register file model.
// Latency: checks accept-to-commit of two cycles via a cycle-stepped reference model.
// Backpressure: random req_valid patterns exercise req_ready stalls and refills.
module tb_regfile_write_arbiter;

   localparam int N = 2;

   logic            clk = 1'b0;
   logic            reset;
   logic [N-1:0]    req_valid;
   logic [N-1:0]    req_ready;
   logic [5*N-1:0]  req_reg;
   logic [32*N-1:0] req_data;
   logic [4:0]      WriteReg;
   logic [31:0]     WriteData;
   logic            RegWrite;
   logic [N-1:0]    grant;
   logic [31:0]     pending;

   always #5 clk = ~clk;

   regfile_write_arbiter #(
      .NUM_REQ (N)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_reg   (req_reg),
      .req_data  (req_data),
      .WriteReg  (WriteReg),
      .WriteData (WriteData),
      .RegWrite  (RegWrite),
      .grant     (grant),
      .pending   (pending)
   );

   // register file committing on the rising edge of the gated clock
   logic        gclk;
   logic [31:0] rf [32];
   assign gclk = clk & RegWrite;
   always @(posedge gclk) rf[WriteReg] <= WriteData;

   // reference model: buffer occupancy, arbitration rule, in-flight writes, committed memory
   typedef struct {
      logic [4:0]  r;
      logic [31:0] d;
      int          c;
   } flight_t;

   logic        mb_valid [N];
   logic [4:0]  mb_reg   [N];
   logic [31:0] mb_data  [N];
`ifdef REGARB_ROUND_ROBIN_EN
   int          mptr;
`endif
   flight_t     flight [$];
   logic [31:0] mmem [32];
   logic        mwr  [32];
   int          cyc;
   int          checks;
   int          errors;
   int          gtally [N];

   task automatic model_reset();
      for (int i = 0; i < N; i++) mb_valid[i] = 1'b0;
      flight.delete();
`ifdef REGARB_ROUND_ROBIN_EN
      mptr = N - 1;
`endif
   endtask

   function automatic logic [N-1:0] model_grant();
      logic [N-1:0] g;
      g = '0;
`ifdef REGARB_ROUND_ROBIN_EN
      for (int k = 1; k <= N; k++) begin
         int idx;
         idx = (mptr + k) % N;
         if (g == '0 && mb_valid[idx]) g[idx] = 1'b1;
      end
`else
      for (int k = 0; k < N; k++) begin
         if (g == '0 && mb_valid[k]) g[k] = 1'b1;
      end
`endif
      return g;
   endfunction

   function automatic logic [31:0] model_pending();
      logic [31:0] p;
      p = '0;
      for (int i = 0; i < N; i++) if (mb_valid[i]) p[mb_reg[i]] = 1'b1;
      foreach (flight[j]) p[flight[j].r] = 1'b1;
      return p;
   endfunction

   // one clock cycle: drive, check arbitration, check launch, step model at the edge, check state
   task automatic run_cycle(input logic [N-1:0] v, input logic [5*N-1:0] r, input logic [32*N-1:0] d);
      logic [N-1:0] eg;
      logic [N-1:0] er;
      logic         exp_we;
      logic [4:0]   exp_r;
      logic [31:0]  exp_d;
      logic [31:0]  exp_p;
      int           bad_r;
      flight_t      f;
      req_valid = v;
      req_reg   = r;
      req_data  = d;
      eg = model_grant();
      for (int i = 0; i < N; i++) er[i] = !mb_valid[i] || eg[i];
      #1;
      checks++;
      if (grant !== eg) begin
         errors++;
         $display("FAIL grant cyc%0d: got %b expected %b", cyc, grant, eg);
      end
      checks++;
      if (req_ready !== er) begin
         errors++;
         $display("FAIL req_ready cyc%0d: got %b expected %b", cyc, req_ready, er);
      end
      for (int i = 0; i < N; i++) gtally[i] += int'(grant[i]);
      @(negedge clk);
      #1;
      exp_we = 1'b0;
      exp_r  = '0;
      exp_d  = '0;
      foreach (flight[j]) begin
         if (flight[j].c == cyc + 1) begin
            exp_we = 1'b1;
            exp_r  = flight[j].r;
            exp_d  = flight[j].d;
         end
      end
      checks++;
      if (RegWrite !== exp_we) begin
         errors++;
         $display("FAIL RegWrite cyc%0d: got %b expected %b", cyc, RegWrite, exp_we);
      end
      if (exp_we) begin
         checks++;
         if ({WriteReg, WriteData} !== {exp_r, exp_d}) begin
            errors++;
            $display("FAIL launch cyc%0d: got r%0d=%h expected r%0d=%h", cyc, WriteReg, WriteData, exp_r, exp_d);
         end
      end
      @(posedge clk);
      cyc++;
      for (int j = flight.size() - 1; j >= 0; j--) begin
         if (flight[j].c == cyc) begin
            mmem[flight[j].r] = flight[j].d;
            mwr[flight[j].r]  = 1'b1;
            flight.delete(j);
         end
      end
      for (int i = 0; i < N; i++) begin
         if (eg[i]) begin
            f.r = mb_reg[i];
            f.d = mb_data[i];
            f.c = cyc + 1;
            flight.push_back(f);
`ifdef REGARB_ROUND_ROBIN_EN
            mptr = i;
`endif
         end
      end
      for (int i = 0; i < N; i++) begin
         if (v[i] && er[i]) begin
            mb_valid[i] = 1'b1;
            mb_reg[i]   = r[5*i +: 5];
            mb_data[i]  = d[32*i +: 32];
         end else if (eg[i]) begin
            mb_valid[i] = 1'b0;
         end
      end
      #1;
      exp_p = model_pending();
      checks++;
      if (pending !== exp_p) begin
         errors++;
         $display("FAIL pending cyc%0d: got %h expected %h", cyc, pending, exp_p);
      end
      bad_r = -1;
      for (int k = 0; k < 32; k++) if (mwr[k] && rf[k] !== mmem[k]) bad_r = k;
      checks++;
      if (bad_r >= 0) begin
         errors++;
         $display("FAIL regfile cyc%0d: r%0d got %h expected %h", cyc, bad_r, rf[bad_r], mmem[bad_r]);
      end
   endtask

   task automatic idle(input int n);
      for (int c = 0; c < n; c++) run_cycle('0, '0, '0);
   endtask

   task automatic apply_reset();
      @(posedge clk);
      #1;
      reset = 1'b1;
      model_reset();
      #2;
      reset = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (req_ready !== 2'b11) begin errors++; $display("FAIL reset_ready: got %b expected 11", req_ready); end
      checks++;
      if (grant !== 2'b00) begin errors++; $display("FAIL reset_grant: got %b expected 00", grant); end
      checks++;
      if ({RegWrite, WriteReg, WriteData} !== 38'd0) begin
         errors++;
         $display("FAIL reset_port: got we=%b r%0d=%h expected all zero", RegWrite, WriteReg, WriteData);
      end
      checks++;
      if (pending !== 32'd0) begin errors++; $display("FAIL reset_pending: got %h expected 0", pending); end
      #2;
      reset = 1'b0;
   endtask

   task automatic test_single_write();
      run_cycle(2'b01, {5'd0, 5'd5}, {32'd0, 32'hDEADBEEF});
      checks++;
      if (pending[5] !== 1'b1) begin errors++; $display("FAIL single_pend_e0: got %b expected 1", pending[5]); end
      idle(1);
      checks++;
      if (pending[5] !== 1'b1) begin errors++; $display("FAIL single_pend_e1: got %b expected 1", pending[5]); end
      idle(1);
      checks++;
      if (pending[5] !== 1'b0) begin errors++; $display("FAIL single_pend_e2: got %b expected 0", pending[5]); end
      checks++;
      if (rf[5] !== 32'hDEADBEEF) begin errors++; $display("FAIL single_commit: got %h expected deadbeef", rf[5]); end
   endtask

   task automatic test_back_to_back();
      logic [5*N-1:0]  r;
      logic [32*N-1:0] d;
      for (int c = 0; c < 9; c++) begin
         if (c == 1) for (int i = 0; i < N; i++) gtally[i] = 0;
         for (int i = 0; i < N; i++) begin
            r[5*i +: 5]   = 5'($urandom_range(31));
            d[32*i +: 32] = $urandom;
         end
         run_cycle(2'b11, r, d);
      end
      checks++;
`ifdef REGARB_ROUND_ROBIN_EN
      if (gtally[0] != 4 || gtally[1] != 4) begin
         errors++;
         $display("FAIL b2b_share: got %0d/%0d grants expected 4/4", gtally[0], gtally[1]);
      end
`else
      if (gtally[0] != 8 || gtally[1] != 0) begin
         errors++;
         $display("FAIL b2b_share: got %0d/%0d grants expected 8/0", gtally[0], gtally[1]);
      end
`endif
      idle(4);
   endtask

   task automatic test_same_reg();
      logic [3:0] obs;
      apply_reset();
      run_cycle(2'b11, {5'd7, 5'd7}, {32'h2, 32'h1});
      obs[0] = pending[7];
      for (int c = 1; c < 4; c++) begin
         idle(1);
         obs[c] = pending[7];
      end
      checks++;
      if (obs !== 4'b0111) begin errors++; $display("FAIL samereg_pend: got %b expected 0111 (E3..E0)", obs); end
      checks++;
      if (rf[7] !== 32'h2) begin errors++; $display("FAIL samereg_final: got %h expected 2", rf[7]); end
   endtask

   task automatic test_reg0();
      run_cycle(2'b10, {5'd0, 5'd0}, {32'hFFFFFFFF, 32'd0});
      idle(3);
      checks++;
      if (rf[0] !== 32'hFFFFFFFF) begin errors++; $display("FAIL reg0_readback: got %h expected ffffffff", rf[0]); end
   endtask

   task automatic test_random();
      logic [N-1:0]    v;
      logic [5*N-1:0]  r;
      logic [32*N-1:0] d;
      for (int c = 0; c < 200; c++) begin
         for (int i = 0; i < N; i++) begin
            v[i]          = ($urandom_range(3) != 0);
            r[5*i +: 5]   = 5'($urandom_range(7));
            d[32*i +: 32] = $urandom;
         end
         run_cycle(v, r, d);
      end
      idle(4);
   endtask

   task automatic test_reset_midflight();
      run_cycle(2'b11, {5'd7, 5'd5}, {32'h1111_1111, 32'h2222_2222});
      idle(1);
      @(negedge clk);
      #1;
      checks++;
      if (RegWrite !== 1'b1) begin errors++; $display("FAIL midrst_launch: got %b expected 1", RegWrite); end
      reset = 1'b1;
      #1;
      checks++;
      if (RegWrite !== 1'b0) begin errors++; $display("FAIL midrst_regwrite: got %b expected 0", RegWrite); end
      checks++;
      if (pending !== 32'd0) begin errors++; $display("FAIL midrst_pending: got %h expected 0", pending); end
      checks++;
      if (req_ready !== 2'b11 || grant !== 2'b00) begin
         errors++;
         $display("FAIL midrst_arb: got ready=%b grant=%b expected 11/00", req_ready, grant);
      end
      model_reset();
      #1;
      reset = 1'b0;
      @(posedge clk);
      #1;
      checks++;
      if (rf[5] !== mmem[5]) begin errors++; $display("FAIL midrst_r5: got %h expected %h", rf[5], mmem[5]); end
      checks++;
      if (rf[7] !== mmem[7]) begin errors++; $display("FAIL midrst_r7: got %h expected %h", rf[7], mmem[7]); end
      idle(2);
   endtask

   initial begin
      checks    = 0;
      errors    = 0;
      cyc       = 0;
      req_valid = '0;
      req_reg   = '0;
      req_data  = '0;
      for (int k = 0; k < 32; k++) begin
         mmem[k] = '0;
         mwr[k]  = 1'b0;
      end
      for (int i = 0; i < N; i++) gtally[i] = 0;
      test_reset();
      test_single_write();
      test_back_to_back();
      test_same_reg();
      test_reg0();
      test_random();
      test_reset_midflight();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
